// File: rtl/cons_pkg.sv
// Shared types and widths for the cons sample-window statistics block.
package cons_pkg;

    localparam int DW   = 8;
    localparam int WIN  = 8;
    localparam int SUMW = DW + $clog2(WIN);

    typedef enum logic {
        EMPTY = 1'b0,
        FILL  = 1'b1
    } cons_state_t;

    // Sum field is sized for the default window; smaller windows use its low bits.
    typedef struct packed {
        logic [SUMW-1:0] sum;
        logic [DW-1:0]   max;
        logic [DW-1:0]   min;
    } cons_rec_t;

    function automatic int sum_width(input int dw, input int win);
        return dw + $clog2(win);
    endfunction

endpackage

// File: rtl/cons_win_acc.sv
// Window accumulator: folds accepted samples into sum/max/min and strobes done
// combinationally with the completing sample so the record lands one edge later.
module cons_win_acc
    import cons_pkg::*;
#(
    parameter int WIN = cons_pkg::WIN
) (
    input  logic          clk,
    input  logic          rst_b,
    input  logic          val_i,
    input  logic [DW-1:0] data_i,
    output logic          done_o,
    output cons_rec_t     rec_o,
    output cons_state_t   state_o
);

    localparam int CW = $clog2(WIN);

    cons_state_t   state_q;
    logic [CW-1:0] cnt_q;
    cons_rec_t     acc_q;
    cons_rec_t     acc_d;

    always_comb begin
        acc_d = acc_q;
        if (state_q == EMPTY) begin
            acc_d.sum = SUMW'(data_i);
            acc_d.max = data_i;
            acc_d.min = data_i;
        end else begin
            acc_d.sum = acc_q.sum + SUMW'(data_i);
            if (data_i > acc_q.max) acc_d.max = data_i;
            if (data_i < acc_q.min) acc_d.min = data_i;
        end
    end

    assign done_o  = val_i && (state_q == FILL) && (cnt_q == CW'(WIN - 1));
    assign rec_o   = acc_d;
    assign state_o = state_q;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else if (val_i) begin
            acc_q <= acc_d;
            if (done_o) begin
                state_q <= EMPTY;
                cnt_q   <= '0;
            end else begin
                state_q <= FILL;
                cnt_q   <= cnt_q + CW'(1);
            end
        end
    end

endmodule

// File: rtl/cons.sv
// Consumer of the val/data stream: per-window statistics into a single-entry
// valid/ready result register with a sticky overrun flag for dropped records.
module cons
    import cons_pkg::*;
#(
    parameter  int WIN = cons_pkg::WIN,
    localparam int RSW = DW + $clog2(WIN)
) (
    input  logic           clk,
    input  logic           rst_b,
    input  logic           val,
    input  logic [DW-1:0]  data,
    input  logic           res_rdy,
    output logic           res_val,
    output logic [RSW-1:0] res_sum,
    output logic [DW-1:0]  res_max,
    output logic [DW-1:0]  res_min,
    output logic           busy,
    output logic           overrun
);

    logic        done;
    cons_rec_t   rec;
    cons_state_t acc_state;

    cons_rec_t res_q, res_d;
    logic      res_val_q, res_val_d;
    logic      ovr_q, ovr_d;

    cons_win_acc #(.WIN(WIN)) u_acc (
        .clk     (clk),
        .rst_b   (rst_b),
        .val_i   (val),
        .data_i  (data),
        .done_o  (done),
        .rec_o   (rec),
        .state_o (acc_state)
    );

    // Valid/ready: a record transfers on an edge where res_val and res_rdy are both high.
    always_comb begin
        res_d     = res_q;
        res_val_d = res_val_q;
        ovr_d     = ovr_q;
        if (done) begin
            if (!res_val_q || res_rdy) begin
                res_d     = rec;
                res_val_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (res_val_q && res_rdy) begin
            res_val_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            res_q     <= '0;
            res_val_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            res_q     <= res_d;
            res_val_q <= res_val_d;
            ovr_q     <= ovr_d;
        end
    end

    assign res_val = res_val_q;
    assign res_sum = res_q.sum[RSW-1:0];
    assign res_max = res_q.max;
    assign res_min = res_q.min;
    assign busy    = (acc_state == FILL);
    assign overrun = ovr_q;

endmodule

// File: tb/tb_cons.sv
// Directed bench for cons: a WIN=4 instance for handshake/overrun/reset cases
// and a WIN=8 instance for the full-width sum and a random-data scoreboard.
module tb_cons;

    logic clk;
    logic rst_b;

    logic       val4, rdy4;
    logic [7:0] data4;
    logic       rv4, busy4, ovr4;
    logic [9:0] sum4;
    logic [7:0] max4, min4;

    logic        val8, rdy8;
    logic [7:0]  data8;
    logic        rv8, busy8, ovr8;
    logic [10:0] sum8;
    logic [7:0]  max8, min8;

    int total = 0;
    int bad   = 0;
    logic [26:0] exp_q[$];

    cons #(.WIN(4)) u4 (
        .clk(clk), .rst_b(rst_b), .val(val4), .data(data4), .res_rdy(rdy4),
        .res_val(rv4), .res_sum(sum4), .res_max(max4), .res_min(min4),
        .busy(busy4), .overrun(ovr4)
    );

    cons #(.WIN(8)) u8 (
        .clk(clk), .rst_b(rst_b), .val(val8), .data(data8), .res_rdy(rdy8),
        .res_val(rv8), .res_sum(sum8), .res_max(max8), .res_min(min8),
        .busy(busy8), .overrun(ovr8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic v, input int s, input int mx,
                        input int mn, input logic b, input logic o);
        chk({tag, ".res_val"}, 32'(rv4), 32'(v));
        chk({tag, ".res_sum"}, 32'(sum4), 32'(s));
        chk({tag, ".res_max"}, 32'(max4), 32'(mx));
        chk({tag, ".res_min"}, 32'(min4), 32'(mn));
        chk({tag, ".busy"}, 32'(busy4), 32'(b));
        chk({tag, ".overrun"}, 32'(ovr4), 32'(o));
    endtask

    task automatic step4(input logic v, input logic [7:0] d, input logic r);
        val4  = v;
        data4 = d;
        rdy4  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic step8(input logic v, input logic [7:0] d, input logic r);
        val8  = v;
        data8 = d;
        rdy8  = r;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_b = 1'b0;
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    initial begin
        int unsigned d, s, mx, mn, g;
        logic [26:0] e;

        rst_b = 1'b0;
        val4 = 1'b0; data4 = '0; rdy4 = 1'b0;
        val8 = 1'b0; data8 = '0; rdy8 = 1'b0;
        #12;
        chk4("reset", 1'b0, 0, 0, 0, 1'b0, 1'b0);
        chk("reset8.res_val", 32'(rv8), 0);
        chk("reset8.res_sum", 32'(sum8), 0);
        @(negedge clk);
        rst_b = 1'b1;

        // Back-to-back window 1,2,3,4 with downstream ready
        step4(1'b1, 8'd1, 1'b1);
        chk("w1.e1.busy", 32'(busy4), 1);
        chk("w1.e1.res_val", 32'(rv4), 0);
        step4(1'b1, 8'd2, 1'b1);
        chk("w1.e2.busy", 32'(busy4), 1);
        step4(1'b1, 8'd3, 1'b1);
        chk("w1.e3.busy", 32'(busy4), 1);
        chk("w1.e3.res_val", 32'(rv4), 0);
        step4(1'b1, 8'd4, 1'b1);
        chk4("w1.done", 1'b1, 10, 4, 1, 1'b0, 1'b0);
        step4(1'b0, 8'd0, 1'b1);
        chk4("w1.taken", 1'b0, 10, 4, 1, 1'b0, 1'b0);

        // Gapped window 5,_,_,_,0,_,5,2
        step4(1'b1, 8'd5, 1'b1);
        repeat (3) step4(1'b0, 8'd99, 1'b1);
        chk("gap.busy", 32'(busy4), 1);
        step4(1'b1, 8'd0, 1'b1);
        step4(1'b0, 8'd77, 1'b1);
        step4(1'b1, 8'd5, 1'b1);
        chk("gap.pre.res_val", 32'(rv4), 0);
        step4(1'b1, 8'd2, 1'b1);
        chk4("gap.done", 1'b1, 12, 5, 0, 1'b0, 1'b0);
        step4(1'b0, 8'd0, 1'b1);
        chk("gap.taken.res_val", 32'(rv4), 0);

        // Backpressure: second record dropped
        repeat (4) step4(1'b1, 8'd1, 1'b0);
        chk4("bp.w1", 1'b1, 4, 1, 1, 1'b0, 1'b0);
        repeat (3) step4(1'b1, 8'd2, 1'b0);
        chk("bp.mid.res_sum", 32'(sum4), 4);
        chk("bp.mid.overrun", 32'(ovr4), 0);
        step4(1'b1, 8'd2, 1'b0);
        chk4("bp.w2", 1'b1, 4, 1, 1, 1'b0, 1'b1);
        step4(1'b0, 8'd0, 1'b1);
        chk4("bp.taken", 1'b0, 4, 1, 1, 1'b0, 1'b1);

        // Take and complete on the same edge
        pulse_reset();
        chk4("sim.reset", 1'b0, 0, 0, 0, 1'b0, 1'b0);
        repeat (4) step4(1'b1, 8'd3, 1'b0);
        chk4("sim.w1", 1'b1, 12, 3, 3, 1'b0, 1'b0);
        step4(1'b1, 8'd6, 1'b0);
        step4(1'b1, 8'd7, 1'b0);
        step4(1'b1, 8'd8, 1'b0);
        step4(1'b1, 8'd9, 1'b1);
        chk4("sim.w2", 1'b1, 30, 9, 6, 1'b0, 1'b0);
        step4(1'b0, 8'd0, 1'b1);
        chk("sim.taken.res_val", 32'(rv4), 0);

        // Asynchronous reset with pending record and partial window
        repeat (4) step4(1'b1, 8'd1, 1'b0);
        repeat (3) step4(1'b1, 8'd4, 1'b0);
        chk("rst.pre.busy", 32'(busy4), 1);
        chk("rst.pre.res_val", 32'(rv4), 1);
        #2;
        rst_b = 1'b0;
        #1;
        chk4("rst.async", 1'b0, 0, 0, 0, 1'b0, 1'b0);
        @(negedge clk);
        rst_b = 1'b1;
        repeat (4) step4(1'b1, 8'd4, 1'b1);
        chk4("rst.after", 1'b1, 16, 4, 4, 1'b0, 1'b0);

        // WIN=8 full-scale samples
        repeat (7) step8(1'b1, 8'd255, 1'b1);
        chk("w8.pre.res_val", 32'(rv8), 0);
        chk("w8.pre.busy", 32'(busy8), 1);
        step8(1'b1, 8'd255, 1'b1);
        chk("w8.res_val", 32'(rv8), 1);
        chk("w8.res_sum", 32'(sum8), 2040);
        chk("w8.res_max", 32'(max8), 255);
        chk("w8.res_min", 32'(min8), 255);
        chk("w8.busy", 32'(busy8), 0);

        // Random gapped data 0..5 against a scoreboard
        for (int w = 0; w < 3; w++) begin
            s = 0; mx = 0; mn = 255;
            for (int i = 0; i < 8; i++) begin
                g = $urandom_range(0, 2);
                repeat (g) step8(1'b0, 8'($urandom_range(0, 255)), 1'b1);
                d = $urandom_range(0, 5);
                s = s + d;
                if (d > mx) mx = d;
                if (d < mn) mn = d;
                step8(1'b1, 8'(d), 1'b1);
                if (i < 7) begin
                    chk($sformatf("rnd%0d.s%0d.busy", w, i), 32'(busy8), 1);
                    chk($sformatf("rnd%0d.s%0d.res_val", w, i), 32'(rv8), 0);
                end
            end
            exp_q.push_back({11'(s), 8'(mx), 8'(mn)});
            chk($sformatf("rnd%0d.res_val", w), 32'(rv8), 1);
            e = exp_q.pop_front();
            chk($sformatf("rnd%0d.record", w), 32'({sum8, max8, min8}), 32'(e));
        end
        chk("rnd.overrun", 32'(ovr8), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cons.md
# cons

Consumer end of the `val`/`data` sample stream driven by the producer block: accepts one 8-bit sample per clock whenever `val` is high and reduces each window of `WIN` accepted samples to a statistics record (sum, max, min). Completed records are handed downstream through a single-entry valid/ready output register. The stream has no backpressure, so a record that cannot be stored is dropped and reported through a sticky overrun flag.

## Interface
- `DW`, 8, sample width; matches producer `data`.
- `WIN`, 8, samples per window; must be ≥ 2.
- `SUMW`, `DW + $clog2(WIN)`, sum width; no overflow is possible.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_b`  in  1  reset; one clock, asynchronous, active-low.
- `val`  in  1  sample valid from the producer; sampled on every rising edge.
- `data`  in  DW  sample value; ignored when `val` = 0.
- `res_rdy`  in  1  downstream ready for a result.
- `res_val`  out  1  result register holds an untaken record.
- `res_sum`  out  SUMW  sum of the window's samples.
- `res_max`  out  DW  largest sample in the window.
- `res_min`  out  DW  smallest sample in the window.
- `busy`  out  1  the current window holds ≥ 1 accepted sample.
- `overrun`  out  1  sticky; set when a completed record was dropped.

## Operation
- Accumulator state: `cnt` (0..WIN-1), `acc_sum`, `acc_max`, `acc_min`.
- FSM states:
  - EMPTY: `cnt` = 0.
  - FILL: 0 < `cnt` < WIN.
- Accepted sample (`val` = 1 on an edge):
  - In EMPTY: load `acc_sum` = `data`, `acc_max` = `data`, `acc_min` = `data`, `cnt` = 1, go to FILL.
  - In FILL: `acc_sum` += `data` (zero-extended to SUMW), `acc_max` = max, `acc_min` = min (unsigned compare), `cnt`++.
- Window completion:
  - Occurs on the edge where an accepted sample brings `cnt` to WIN.
  - The completing record includes that sample.
  - The accumulators return to EMPTY on the same edge; no sample is lost between windows.
- `val` = 0 cycles leave all accumulator state unchanged; gaps are allowed anywhere.
- Result register, on a completion edge:
  - If `res_val` = 0, or `res_val` = 1 and `res_rdy` = 1: load the new record and set `res_val` = 1. This is the simultaneous take-and-complete case; no overrun.
  - If `res_val` = 1 and `res_rdy` = 0: keep the old record, discard the new one, set `overrun` = 1.
- Result register, without completion: if `res_val` = 1 and `res_rdy` = 1, clear `res_val`.
- The `res_*` data outputs hold their last value after being taken.
- `overrun` clears only on reset.
- `busy` = (state == FILL).
- `res_rdy` has no effect while `res_val` = 0.

## Timing
- Reset values:
  - `res_val` = 0, `res_sum` = 0, `res_max` = 0, `res_min` = 0.
  - `busy` = 0, `overrun` = 0.
  - State = EMPTY, `cnt` = 0.
- Reset asserted mid-window or with a pending record: the partial window and the record are lost immediately, with no clock needed.
- Latency: the record is visible on `res_*` with `res_val` = 1 directly after the completing edge (1 cycle from the last sample).
- Sustained throughput: one sample per clock. A window completes at most every WIN cycles, so a ready-high downstream never overruns.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Package `cons_pkg`:
  - `DW` and `WIN` defaults.
  - The `SUMW` derivation.
  - FSM state enum `cons_state_t` {EMPTY, FILL}.
  - Packed record typedef `cons_rec_t` {sum, max, min}.
- Sub-module `cons_win_acc`: accumulator, counter and FSM. It outputs a one-cycle `done` strobe with the completed `cons_rec_t`.
- Top level `cons`: result register, handshake and overrun logic.

## Test plan
- Reset, `WIN` = 4: samples 1, 2, 3, 4 on consecutive cycles with `res_rdy` = 1. Expect a one-cycle `res_val` with sum = 10, max = 4, min = 1; `busy` high from the 1st to the 4th edge.
- Gapped stream: samples 5, (gap ×3), 0, (gap), 5, 2. Expect sum = 12, max = 5, min = 0, with `res_val` only after the sample 2.
- Backpressure, `res_rdy` = 0: two full windows, 1,1,1,1 then 2,2,2,2. Expect the record to stay at sum = 4 and `overrun` = 1 after the 8th sample. After raising `res_rdy`, `res_val` drops and `overrun` stays 1.
- Simultaneous events: `res_rdy` rises on the same edge that completes the second window. Expect `res_val` to stay 1, the record to become the second window's, and `overrun` = 0.
- Reset mid-operation: release reset, feed 3 samples of 4, assert `rst_b` low between edges. Expect all outputs at 0 immediately. After release, 4,4,4,4 gives sum = 16, proving the partial window was discarded.
- Width edge, `WIN` = 8: eight samples of 255. Expect `res_sum` = 2040 (11 bits, no wrap), max = min = 255. Also random producer data 0..5 checked against a scoreboard.
